// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch and data) sharing one single-port memory.
// Data wins contention until a burst limit, then fetch is forced in; stuck transfers abort on timeout.
`timescale 1ns/1ps

// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no memory request; arbitration between eligible requesters
// ST_BUSY_I | fetch transaction on the memory port, waiting for mem_ready
// ST_BUSY_D | data transaction on the memory port, waiting for mem_ready
module mem_port_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] streak;
    logic [3:0] streak_inc;
    logic [7:0] wait_cnt;

    logic in_idle;
    logic busy;
    logic fetch_elig;
    logic data_elig;
    logic grant_d;
    logic grant_i;
    logic timed_out;
    logic finish;
    logic fin_i;
    logic fin_d;

    // A requester being acked this cycle is still holding req for that ack, not asking again.
    assign fetch_elig = if_req & ~if_ack;
    assign data_elig  = d_req & ~d_ack;

    assign in_idle = (state == ST_IDLE);
    assign busy    = (state == ST_BUSY_I) | (state == ST_BUSY_D);

    assign grant_d = in_idle & data_elig & (~fetch_elig | (streak < BURST_MAX));
    assign grant_i = in_idle & fetch_elig & ~grant_d;

    assign timed_out = busy & ~mem_ready & (wait_cnt == WAIT_LAST);
    assign finish    = busy & (mem_ready | timed_out);
    assign fin_i     = finish & (state == ST_BUSY_I);
    assign fin_d     = finish & (state == ST_BUSY_D);

    assign streak_inc = (streak >= BURST_MAX) ? BURST_MAX : streak + 4'd1;

    assign mem_req   = busy;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_d) begin
                    state_nxt = ST_BUSY_D;
                end else if (grant_i) begin
                    state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I,
            ST_BUSY_D: begin
                if (finish) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            streak   <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Streak only counts data grants that actually made fetch wait.
            if (grant_d) begin
                streak <= fetch_elig ? streak_inc : 4'd0;
            end else if (grant_i) begin
                streak <= '0;
            end

            if (grant_d || grant_i) begin
                wait_cnt <= '0;
            end else if (busy && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            bus_err  <= 1'b0;
        end else begin
            if_ack <= fin_i;
            d_ack  <= fin_d;

            // An aborted transfer returns zero; stores never return memory data.
            if (fin_i) begin
                if_rdata <= mem_ready ? mem_rdata : 32'd0;
            end
            if (fin_d) begin
                d_rdata <= (mem_ready && !mem_we) ? mem_rdata : 32'd0;
            end

            if (timed_out) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for burst limiting, stores, timeout and reset during a transfer.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    int n_cmp = 0;
    int n_mis = 0;

    mem_port_arbiter #(
        .MAX_DATA_BURST(4),
        .TIMEOUT       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic        mem_ready;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic        e_if_ack;
        logic        e_d_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
        logic        e_stall_if;
        logic        e_stall_mem;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    initial begin
        // inputs: if_req if_addr d_req d_we d_addr d_wdata mem_rdata mem_ready
        // expect: mem_req mem_we mem_addr if_ack d_ack if_rdata d_rdata stall_if stall_mem
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13, 1'b1,
                     1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13, 1'b1,
                     1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13, 1'b1,
                     1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0,
                     1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0,
                     1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77, 1'b1,
                     1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77, 1'b1,
                     1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h77, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 32'h0, 32'h99, 1'b1,
                     1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h77, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2000, 32'h0, 32'hCAFE0001, 1'b1,
                     1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h77, 32'h0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2000, 32'h0, 32'hCAFE0001, 1'b1,
                     1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h77, 32'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h2000, 32'h0, 32'hCAFE0001, 1'b1,
                     1'b0, 1'b0, 32'h2000, 1'b0, 1'b1, 32'h77, 32'hCAFE0001, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h2000, 32'h0, 32'hCAFE0001, 1'b1,
                     1'b0, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h77, 32'hCAFE0001, 1'b0, 1'b0};

        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        repeat (2) obs();
        check("rst_mem_req",  mem_req,  0);
        check("rst_mem_we",   mem_we,   0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_ack",   if_ack,   0);
        check("rst_d_ack",    d_ack,    0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata",  d_rdata,  0);
        check("rst_bus_err",  bus_err,  0);
        rst = 1'b1;

        // Fetch-only, ack-cycle exclusion, delayed ready, idle ready ignored, load.
        for (int i = 0; i < 12; i++) begin
            cyc();
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            d_req     = vecs[i].d_req;
            d_we      = vecs[i].d_we;
            d_addr    = vecs[i].d_addr;
            d_wdata   = vecs[i].d_wdata;
            mem_rdata = vecs[i].mem_rdata;
            mem_ready = vecs[i].mem_ready;
            obs();
            check($sformatf("vec%0d_mem_req", i),   mem_req,   vecs[i].e_mem_req);
            check($sformatf("vec%0d_mem_we", i),    mem_we,    vecs[i].e_mem_we);
            check($sformatf("vec%0d_mem_addr", i),  mem_addr,  vecs[i].e_mem_addr);
            check($sformatf("vec%0d_if_ack", i),    if_ack,    vecs[i].e_if_ack);
            check($sformatf("vec%0d_d_ack", i),     d_ack,     vecs[i].e_d_ack);
            check($sformatf("vec%0d_if_rdata", i),  if_rdata,  vecs[i].e_if_rdata);
            check($sformatf("vec%0d_d_rdata", i),   d_rdata,   vecs[i].e_d_rdata);
            check($sformatf("vec%0d_stall_if", i),  stall_if,  vecs[i].e_stall_if);
            check($sformatf("vec%0d_stall_mem", i), stall_mem, vecs[i].e_stall_mem);
        end

        // Burst limit: fetch raised with each data request; expected grants D,D,D,D,I,D.
        for (int i = 0; i < 5; i++) begin
            cyc();
            if_req    = 1'b1;
            if_addr   = 32'h300;
            d_req     = 1'b1;
            d_we      = 1'b0;
            d_addr    = 32'h2000;
            mem_ready = 1'b1;
            mem_rdata = 32'hA000_0000 + 32'(i);
            obs();
            check("burst_stall_if", stall_if, 1);
            check("burst_idle_mem_req", mem_req, 0);
            cyc();
            if (i < 4) if_req = 1'b0;
            obs();
            check($sformatf("burst%0d_mem_req", i), mem_req, 1);
            check($sformatf("burst%0d_grant_addr", i), mem_addr, (i < 4) ? 32'h2000 : 32'h300);
            cyc();
            obs();
            if (i < 4) begin
                check($sformatf("burst%0d_d_ack", i), d_ack, 1);
                check($sformatf("burst%0d_d_rdata", i), d_rdata, 32'hA000_0000 + 32'(i));
                check($sformatf("burst%0d_no_regrant", i), mem_req, 0);
            end else begin
                check("burst4_if_ack", if_ack, 1);
                check("burst4_if_rdata", if_rdata, 32'hA000_0004);
            end
        end
        cyc();
        if_req = 1'b0;
        obs();
        check("burst5_mem_req", mem_req, 1);
        check("burst5_grant_addr", mem_addr, 32'h2000);
        cyc();
        obs();
        check("burst5_d_ack", d_ack, 1);
        cyc();
        d_req = 1'b0;
        obs();
        check("burst_end_mem_req", mem_req, 0);

        // Both held continuously: data first, then fetch wins in the data ack cycle.
        cyc();
        if_req    = 1'b1;
        if_addr   = 32'h300;
        d_req     = 1'b1;
        d_addr    = 32'h2000;
        mem_rdata = 32'hB1;
        mem_ready = 1'b1;
        obs();
        check("held_stall_if_c0", stall_if, 1);
        check("held_stall_mem_c0", stall_mem, 1);
        cyc();
        obs();
        check("held_first_grant", mem_addr, 32'h2000);
        check("held_stall_if_c1", stall_if, 1);
        cyc();
        obs();
        check("held_d_ack", d_ack, 1);
        check("held_stall_mem_ack", stall_mem, 0);
        check("held_stall_if_c2", stall_if, 1);
        cyc();
        obs();
        check("held_second_grant", mem_addr, 32'h300);
        check("held_second_mem_req", mem_req, 1);
        cyc();
        obs();
        check("held_if_ack", if_ack, 1);
        check("held_stall_if_ack", stall_if, 0);
        check("held_acks_exclusive", d_ack, 0);
        cyc();
        if_req = 1'b0;
        obs();
        check("held_third_grant", mem_addr, 32'h2000);
        cyc();
        obs();
        check("held_third_d_ack", d_ack, 1);
        cyc();
        d_req = 1'b0;
        obs();
        check("held_end_mem_req", mem_req, 0);

        // Store with three wait cycles.
        cyc();
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h40;
        d_wdata   = 32'hDEADBEEF;
        mem_ready = 1'b0;
        mem_rdata = 32'h12345678;
        obs();
        check("st_idle_mem_req", mem_req, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            mem_ready = (k == 4);
            obs();
            check($sformatf("st_busy%0d_mem_req", k), mem_req, 1);
            check($sformatf("st_busy%0d_mem_we", k), mem_we, 1);
            check($sformatf("st_busy%0d_mem_addr", k), mem_addr, 32'h40);
            check($sformatf("st_busy%0d_mem_wdata", k), mem_wdata, 32'hDEADBEEF);
            check($sformatf("st_busy%0d_d_ack", k), d_ack, 0);
        end
        cyc();
        obs();
        check("st_d_ack", d_ack, 1);
        check("st_d_rdata", d_rdata, 0);
        check("st_bus_err", bus_err, 0);
        check("st_done_mem_req", mem_req, 0);
        cyc();
        d_req = 1'b0;
        d_we  = 1'b0;
        obs();
        check("st_ack_one_cycle", d_ack, 0);

        // Timeout after 8 stalled busy cycles.
        cyc();
        d_req     = 1'b1;
        d_addr    = 32'h80;
        mem_ready = 1'b0;
        mem_rdata = 32'hFFFF0000;
        obs();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            obs();
            check($sformatf("to_busy%0d_mem_req", k), mem_req, 1);
            check($sformatf("to_busy%0d_d_ack", k), d_ack, 0);
            check($sformatf("to_busy%0d_bus_err", k), bus_err, 0);
        end
        cyc();
        obs();
        check("to_d_ack", d_ack, 1);
        check("to_d_rdata", d_rdata, 0);
        check("to_bus_err", bus_err, 1);
        check("to_mem_req", mem_req, 0);
        cyc();
        d_req = 1'b0;
        obs();
        check("to_ack_one_cycle", d_ack, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            obs();
            check("to_bus_err_sticky", bus_err, 1);
        end

        // Reset in the middle of a data transfer.
        cyc();
        d_req  = 1'b1;
        d_addr = 32'h500;
        obs();
        cyc();
        obs();
        check("rm_busy_mem_req", mem_req, 1);
        check("rm_busy_mem_addr", mem_addr, 32'h500);
        #2;
        rst = 1'b0;
        #1;
        check("rm_async_mem_req", mem_req, 0);
        check("rm_async_mem_addr", mem_addr, 0);
        check("rm_async_bus_err", bus_err, 0);
        check("rm_async_d_ack", d_ack, 0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("rm_hold_d_ack", d_ack, 0);
            check("rm_hold_mem_req", mem_req, 0);
        end
        obs();
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h600DF00D;
        cyc();
        check("rm_regrant_mem_req", mem_req, 1);
        check("rm_regrant_mem_addr", mem_addr, 32'h500);
        cyc();
        check("rm_d_ack", d_ack, 1);
        check("rm_d_rdata", d_rdata, 32'h600DF00D);
        d_req = 1'b0;
        obs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
